// File: rtl/foc_sequencer.sv
// foc_sequencer: per-PWM-period scheduler for the FOC datapath.
// Each accepted sync pulse runs one pass through NUM_STAGES transform
// stages (clarke, park, PI, inverse park), issuing a one-cycle start to each
// stage and waiting for its done, then pulses update to the PWM/SVM block.
// Stage timeouts park the sequencer in FAULT; syncs that arrive while an
// iteration is in flight are dropped and flagged as overrun.
// Optional build macro FOC_LATENCY_MON_EN adds a max_latency output that
// records the longest sync-to-update time seen.

module foc_sequencer #(
   parameter int NUM_STAGES  = 4,
   parameter int TIMEOUT_CYC = 64,
   parameter int CNT_WIDTH   = 16,
   localparam int IDX_W      = $clog2(NUM_STAGES)
) (
   input  logic                  clk,
   input  logic                  rstb,
   input  logic                  enable,
   input  logic                  sync,
   input  logic [NUM_STAGES-1:0] stage_done,
   input  logic                  clear_fault,
   output logic [NUM_STAGES-1:0] stage_start,
   output logic                  update,
   output logic                  busy,
   output logic                  fault,
   output logic [IDX_W-1:0]      fault_stage,
   output logic                  overrun,
   output logic [CNT_WIDTH-1:0]  iter_count
`ifdef FOC_LATENCY_MON_EN
   ,
   output logic [15:0]           max_latency
`endif
);

   // The timer only has to count up to TIMEOUT_CYC-2; the fault is taken on
   // the wait cycle that would make it reach TIMEOUT_CYC-1, so FAULT appears
   // exactly TIMEOUT_CYC cycles after the start pulse of a silent stage.
   localparam int TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TMR_W-1:0] TIMER_LAST = TMR_W'(TIMEOUT_CYC - 2);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_STAGES - 1);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      COMMIT,
      FAULT
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic             fault_set;

   // State, stage index and wait timer registers.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q <= IDLE;
         idx_q   <= '0;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         timer_q <= timer_d;
      end
   end

   // Next-state logic and outputs decoded purely from the registered state.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      timer_d     = timer_q;
      fault_set   = 1'b0;
      stage_start = '0;
      update      = 1'b0;
      busy        = 1'b0;
      fault       = 1'b0;

      case (state_q)
         IDLE: begin
            if (sync && enable) begin
               state_d = ISSUE;
               idx_d   = '0;
            end
         end

         ISSUE: begin
            for (int i = 0; i < NUM_STAGES; i++) begin
               stage_start[i] = (idx_q == IDX_W'(i));
            end
            busy    = 1'b1;
            timer_d = '0;
            state_d = WAIT;
         end

         WAIT: begin
            busy = 1'b1;
            if (stage_done[idx_q]) begin
               if (idx_q == IDX_LAST) begin
                  state_d = COMMIT;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = ISSUE;
               end
            end else if (timer_q == TIMER_LAST) begin
               state_d   = FAULT;
               fault_set = 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end

         COMMIT: begin
            update = 1'b1;
            busy   = 1'b1;
            if (sync && enable) begin
               state_d = ISSUE;
               idx_d   = '0;
            end else begin
               state_d = IDLE;
            end
         end

         FAULT: begin
            fault = 1'b1;
            if (clear_fault) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Remember which stage timed out; the value survives clear_fault.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         fault_stage <= '0;
      end else if (fault_set) begin
         fault_stage <= idx_q;
      end
   end

   // Sticky overrun: a sync during ISSUE/WAIT is dropped and flagged.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         overrun <= 1'b0;
      end else begin
         if (clear_fault) begin
            overrun <= 1'b0;
         end
         if (sync && ((state_q == ISSUE) || (state_q == WAIT))) begin
            overrun <= 1'b1;
         end
      end
   end

   // Completed-iteration counter, wraps naturally at 2^CNT_WIDTH.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         iter_count <= '0;
      end else if (state_q == COMMIT) begin
         iter_count <= iter_count + 1'b1;
      end
   end

`ifdef FOC_LATENCY_MON_EN
   logic        iter_start;
   logic [15:0] lat_cnt_q;
   logic [16:0] lat_sum;
   logic [15:0] lat_next;

   assign iter_start = sync && enable && ((state_q == IDLE) || (state_q == COMMIT));
   assign lat_sum    = {1'b0, lat_cnt_q} + 17'd1;
   assign lat_next   = lat_sum[16] ? 16'hFFFF : lat_sum[15:0];

   // Saturating cycle counter restarted by every accepted sync.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         lat_cnt_q <= '0;
      end else if (iter_start) begin
         lat_cnt_q <= '0;
      end else begin
         lat_cnt_q <= lat_next;
      end
   end

   // Track the worst sync-to-update latency; clear_fault zeroes it.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         max_latency <= '0;
      end else if (clear_fault) begin
         max_latency <= '0;
      end else if ((state_q == COMMIT) && (lat_next > max_latency)) begin
         max_latency <= lat_next;
      end
   end
`endif

endmodule

// File: tb/tb_foc_sequencer.sv
// tb_foc_sequencer: self-checking bench for foc_sequencer.
// Expected behaviour comes from a timing model: each stage start lands one
// cycle after the previous done, update one cycle after the last done, and a
// silent stage faults TIMEOUT_CYC cycles after its start. Works with or
// without FOC_LATENCY_MON_EN.

module tb_foc_sequencer;

   localparam int NS  = 4;
   localparam int TMO = 64;
   localparam int CW  = 4;
   localparam int IW  = 2;

   logic          clk         = 1'b0;
   logic          rstb        = 1'b1;
   logic          enable      = 1'b0;
   logic          sync        = 1'b0;
   logic          clear_fault = 1'b0;
   logic [NS-1:0] stage_done  = '0;
   logic [NS-1:0] stage_start;
   logic          update;
   logic          busy;
   logic          fault;
   logic [IW-1:0] fault_stage;
   logic          overrun;
   logic [CW-1:0] iter_count;
`ifdef FOC_LATENCY_MON_EN
   logic [15:0]   max_latency;
`endif

   foc_sequencer #(
      .NUM_STAGES  (NS),
      .TIMEOUT_CYC (TMO),
      .CNT_WIDTH   (CW)
   ) dut (
      .clk         (clk),
      .rstb        (rstb),
      .enable      (enable),
      .sync        (sync),
      .stage_done  (stage_done),
      .clear_fault (clear_fault),
      .stage_start (stage_start),
      .update      (update),
      .busy        (busy),
      .fault       (fault),
      .fault_stage (fault_stage),
      .overrun     (overrun),
      .iter_count  (iter_count)
`ifdef FOC_LATENCY_MON_EN
      ,
      .max_latency (max_latency)
`endif
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   int nCompared   = 0;
   int nMismatched = 0;

   int expIter       = 0;
   int expOverrun    = 0;
   int expFault      = 0;
   int expFaultStage = 0;
   int expMaxLat     = 0;
   int dly [NS];

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nCompared++;
      assert (observed === expected) else begin
         nMismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkCycle(input string tag, input int expStart, input int expUpd, input int expBusy);
      checkOutput({tag, "/stage_start"}, 32'(stage_start), expStart);
      checkOutput({tag, "/update"},      32'(update),      expUpd);
      checkOutput({tag, "/busy"},        32'(busy),        expBusy);
      checkOutput({tag, "/fault"},       32'(fault),       expFault);
      checkOutput({tag, "/fault_stage"}, 32'(fault_stage), expFaultStage);
      checkOutput({tag, "/overrun"},     32'(overrun),     expOverrun);
      checkOutput({tag, "/iter_count"},  32'(iter_count),  expIter);
`ifdef FOC_LATENCY_MON_EN
      checkOutput({tag, "/max_latency"}, 32'(max_latency), expMaxLat);
`endif
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic holdCycles(input string tag, input int n);
      for (int k = 0; k < n; k++) begin
         tick();
         checkCycle(tag, 0, 0, 0);
         sync        = 1'b0;
         clear_fault = 1'b0;
      end
   endtask

   task automatic pulseClear(input string tag);
      clear_fault = 1'b1;
      expFault    = 0;
      expOverrun  = 0;
      expMaxLat   = 0;
      holdCycles(tag, 2);
   endtask

   // One iteration driven from dly[]; hang>=0 names a stage that never answers,
   // ovRel>0 (or -1 for random) re-pulses sync at that relative cycle.
   task automatic applyStimulus(input string tag, input int hang, input int ovRelIn,
                                input int enDropRel, input bit chainIn, input bit chainOut);
      int startRel [NS];
      int updRel;
      int faultRel;
      int endRel;
      int lastStage;
      int act;
      int expStart;
      int ovRel;
      logic [NS-1:0] doneVec;

      startRel[0] = 1;
      for (int i = 1; i < NS; i++) startRel[i] = startRel[i-1] + dly[i-1] + 1;
      updRel    = startRel[NS-1] + dly[NS-1] + 1;
      lastStage = (hang >= 0) ? hang : NS - 1;
      faultRel  = (hang >= 0) ? startRel[lastStage] + TMO : 0;
      endRel    = (hang >= 0) ? faultRel : updRel;
      ovRel     = (ovRelIn < 0) ? int'($urandom_range(1, endRel - 1)) : ovRelIn;

      if (!chainIn) begin
         tick();
         checkCycle({tag, "/pre"}, 0, 0, 0);
         sync   = 1'b1;
         enable = 1'b1;
      end

      for (int rel = 1; rel <= endRel; rel++) begin
         tick();
         sync     = 1'b0;
         act      = 0;
         expStart = 0;
         for (int i = 0; i <= lastStage; i++) begin
            if (startRel[i] <= rel) act = i;
            if (startRel[i] == rel) expStart = 1 << i;
         end
         if (ovRel > 0 && rel == ovRel + 1) expOverrun = 1;
         if (hang >= 0 && rel == faultRel) begin
            expFault      = 1;
            expFaultStage = hang;
         end
         checkCycle(tag, expStart,
                    (hang < 0 && rel == updRel) ? 1 : 0,
                    (hang >= 0 && rel >= faultRel) ? 0 : 1);

         doneVec      = NS'($urandom());
         doneVec[act] = 1'b0;
         if (act != hang && rel == startRel[act] + dly[act]) doneVec[act] = 1'b1;
         stage_done = doneVec;
         if (rel == ovRel) sync = 1'b1;
         if (rel == enDropRel) enable = 1'b0;
         if (chainOut && rel == updRel) begin
            sync   = 1'b1;
            enable = 1'b1;
         end
      end

      if (!chainOut) stage_done = '0;
      if (hang < 0) begin
         expIter = (expIter + 1) % (1 << CW);
         if (updRel > expMaxLat) expMaxLat = updRel;
      end
   endtask

   task automatic setDelays(input int a, input int b, input int c, input int d);
      dly[0] = a;
      dly[1] = b;
      dly[2] = c;
      dly[3] = d;
   endtask

   task automatic randomDelays();
      for (int i = 0; i < NS; i++) dly[i] = int'($urandom_range(1, 5));
   endtask

   // Directed scenarios followed by a randomized run, all in sequence.
   initial begin
      bit chainPrev;
      bit chainNow;

      #1 rstb = 1'b0;
      #1 checkCycle("reset", 0, 0, 0);
      tick();
      tick();
      rstb = 1'b1;

      $display("[TB] basic iteration, 1-cycle stages");
      setDelays(1, 1, 1, 1);
      applyStimulus("basic", -1, 0, 0, 1'b0, 1'b0);
      holdCycles("basic_after", 2);

      $display("[TB] sync with enable low is ignored");
      enable = 1'b0;
      sync   = 1'b1;
      holdCycles("en_low", 4);

      $display("[TB] enable dropped during stage 1");
      setDelays(2, 2, 2, 2);
      applyStimulus("en_drop", -1, 0, 5, 1'b0, 1'b0);
      holdCycles("en_drop_after", 2);

      $display("[TB] overrun during WAIT of stage 1");
      setDelays(1, 3, 1, 1);
      applyStimulus("overrun", -1, 4, 0, 1'b0, 1'b0);
      holdCycles("overrun_after", 2);
      pulseClear("clear_no_fault");

      $display("[TB] sync coincident with COMMIT");
      randomDelays();
      applyStimulus("chain_a", -1, 0, 0, 1'b0, 1'b1);
      randomDelays();
      applyStimulus("chain_b", -1, 0, 0, 1'b1, 1'b0);
      holdCycles("chain_after", 2);

      $display("[TB] stage 2 timeout");
      setDelays(1, 1, 1, 1);
      applyStimulus("timeout", 2, 0, 0, 1'b0, 1'b0);
      sync   = 1'b1;
      enable = 1'b1;
      holdCycles("fault_sync", 6);
      pulseClear("fault_clear");
      setDelays(1, 1, 1, 1);
      applyStimulus("post_fault", -1, 0, 0, 1'b0, 1'b0);
      holdCycles("post_fault_after", 2);

      $display("[TB] random timeout with overrun");
      randomDelays();
      applyStimulus("rnd_timeout", int'($urandom_range(0, NS - 1)), -1, 0, 1'b0, 1'b0);
      holdCycles("rnd_fault_hold", 3);
      pulseClear("rnd_fault_clear");

      $display("[TB] randomized iterations");
      chainPrev = 1'b0;
      for (int k = 0; k < 20; k++) begin
         randomDelays();
         chainNow = (k < 19) && ($urandom_range(0, 2) == 0);
         applyStimulus("rnd_iter", -1, ($urandom_range(0, 2) == 0) ? -1 : 0, 0, chainPrev, chainNow);
         if (!chainNow) holdCycles("rnd_gap", int'($urandom_range(0, 3)));
         chainPrev = chainNow;
      end
      if (expOverrun != 0) pulseClear("rnd_clear");

      $display("[TB] reset during WAIT of stage 3");
      tick();
      checkCycle("rst_pre", 0, 0, 0);
      sync       = 1'b1;
      enable     = 1'b1;
      stage_done = '0;
      for (int rel = 1; rel <= 8; rel++) begin
         tick();
         sync       = 1'b0;
         stage_done = (rel == 2) ? 4'b0001 : (rel == 4) ? 4'b0010 : (rel == 6) ? 4'b0100 : 4'b0000;
      end
      checkOutput("rst_busy_before", 32'(busy), 1);
      #1 rstb = 1'b0;
      #1;
      expIter       = 0;
      expOverrun    = 0;
      expFault      = 0;
      expFaultStage = 0;
      expMaxLat     = 0;
      checkCycle("rst_async", 0, 0, 0);
      #1 rstb = 1'b1;
      holdCycles("rst_after", 3);

      $display("[TB] latency with stage delays 1,3,1,1");
      setDelays(1, 3, 1, 1);
      applyStimulus("lat", -1, 0, 0, 1'b0, 1'b0);
      holdCycles("lat_after", 1);
`ifdef FOC_LATENCY_MON_EN
      checkOutput("maxlat_1311", 32'(max_latency), 11);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
